// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 register-file types and condition-code constants
package lc3_pkg;

  typedef logic [2:0] reg_idx_t;
  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_N     = 3'b100;
  localparam nzp_t NZP_Z     = 3'b010;
  localparam nzp_t NZP_P     = 3'b001;
  localparam nzp_t NZP_RESET = NZP_Z;

endpackage

// File: rtl/nzp_gen.sv
// rtl/nzp_gen.sv - maps a bus value to its one-hot {N,Z,P} condition code
module nzp_gen
  import lc3_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] data,
  output nzp_t         cc
);

  // Sign bit wins first so the most-negative value reports N; otherwise zero vs positive.
  always_comb begin
    cc = NZP_P;
    if (data[N-1]) begin
      cc = NZP_N;
    end else if (data == '0) begin
      cc = NZP_Z;
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - LC-3 R0-R7 register file with two read ports and NZP register
module register_file
  import lc3_pkg::*;
#(
  parameter int N      = 16,
  parameter bit BYPASS = 1'b1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         LD_REG,
  input  reg_idx_t     DR,
  input  reg_idx_t     SR1,
  input  reg_idx_t     SR2,
  input  logic         LD_CC,
  input  logic [N-1:0] In,
  output logic [N-1:0] SR1_Out,
  output logic [N-1:0] SR2_Out,
  output nzp_t         NZP
);

  logic [N-1:0] regs [8];
  nzp_t         next_cc;
  logic         write_lands;

  nzp_gen #(.N(N)) u_nzp_gen (
    .data (In),
    .cc   (next_cc)
  );

  // A write only lands when Reset is low, so write-through is suppressed during reset too.
  assign write_lands = LD_REG && !Reset;

  // Register array and condition codes; reset clears everything and discards that cycle's loads.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
      NZP <= NZP_RESET;
    end else begin
      if (LD_REG) begin
        regs[DR] <= In;
      end
      if (LD_CC) begin
        NZP <= next_cc;
      end
    end
  end

  // Zero-latency read muxes, optionally forwarding the value being written this cycle.
  always_comb begin
    SR1_Out = regs[SR1];
    SR2_Out = regs[SR2];
    if (BYPASS && write_lands && (SR1 == DR)) begin
      SR1_Out = In;
    end
    if (BYPASS && write_lands && (SR2 == DR)) begin
      SR2_Out = In;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file, bypass and non-bypass builds
module tb_register_file;
  import lc3_pkg::*;

  logic        clk;
  logic        rst;
  logic        ld_reg;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic        ld_cc;
  logic [15:0] din;
  logic [15:0] a1, a2, b1, b2;
  logic [2:0]  nzp_a, nzp_b;

  register_file #(.N(16), .BYPASS(1'b1)) u_byp (
    .Clk(clk), .Reset(rst), .LD_REG(ld_reg), .DR(dr), .SR1(sr1), .SR2(sr2),
    .LD_CC(ld_cc), .In(din), .SR1_Out(a1), .SR2_Out(a2), .NZP(nzp_a)
  );

  register_file #(.N(16), .BYPASS(1'b0)) u_nob (
    .Clk(clk), .Reset(rst), .LD_REG(ld_reg), .DR(dr), .SR1(sr1), .SR2(sr2),
    .LD_CC(ld_cc), .In(din), .SR1_Out(b1), .SR2_Out(b2), .NZP(nzp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] a1, a2, b1, b2;
    logic [2:0]  nzp;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] mem [8];
  logic [2:0]  m_nzp;

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'd0) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: expected outputs for this cycle go to the scoreboard, then the model advances.
  task automatic cycle(input bit r, input bit lr, input logic [2:0] d, input logic [2:0] s1,
                       input logic [2:0] s2, input bit lc, input logic [15:0] v,
                       input bit chk, input string nm);
    exp_t e;
    rst = r; ld_reg = lr; dr = d; sr1 = s1; sr2 = s2; ld_cc = lc; din = v;
    if (chk) begin
      e.name = nm;
      e.b1 = mem[s1];
      e.b2 = mem[s2];
      e.a1 = (lr && !r && s1 == d) ? v : mem[s1];
      e.a2 = (lr && !r && s2 == d) ? v : mem[s2];
      e.nzp = m_nzp;
      sb.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'd0;
      m_nzp = 3'b010;
    end else begin
      if (lr) mem[d] = v;
      if (lc) m_nzp = cc_of(v);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle and compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".byp_sr1"}, a1, e.a1);
        check({e.name, ".byp_sr2"}, a2, e.a2);
        check({e.name, ".nob_sr1"}, b1, e.b1);
        check({e.name, ".nob_sr2"}, b2, e.b2);
        check({e.name, ".byp_nzp"}, {13'd0, nzp_a}, {13'd0, e.nzp});
        check({e.name, ".nob_nzp"}, {13'd0, nzp_b}, {13'd0, e.nzp});
        check({e.name, ".onehot"}, {15'd0, $onehot(nzp_a) && $onehot(nzp_b)}, 16'd1);
      end
    end
  end

  initial begin
    logic [15:0] v;
    logic [2:0]  xdr;
    for (int i = 0; i < 8; i++) mem[i] = 16'd0;
    m_nzp = 3'b010;
    rst = 1'b0; ld_reg = 1'b0; dr = 3'd0; sr1 = 3'd0; sr2 = 3'd0; ld_cc = 1'b0; din = 16'd0;
    @(posedge clk);
    #1;

    cycle(1, 0, 0, 0, 0, 0, 16'h0, 0, "first_reset");
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 3'(2 * i), 3'(2 * i + 1), 0, 16'h0, 1, "reset_read");

    cycle(0, 1, 3, 3, 5, 0, 16'h1234, 1, "wr_r3");
    cycle(0, 1, 5, 3, 5, 0, 16'hBEEF, 1, "wr_r5");
    cycle(0, 0, 0, 3, 5, 0, 16'h0, 1, "rd_r3_r5");
    cycle(0, 0, 0, 0, 1, 0, 16'h0, 1, "rd_others_a");
    cycle(0, 0, 0, 2, 4, 0, 16'h0, 1, "rd_others_b");
    cycle(0, 0, 0, 6, 7, 0, 16'h0, 1, "rd_others_c");

    cycle(0, 0, 0, 0, 0, 1, 16'h8000, 1, "cc_neg");
    cycle(0, 0, 0, 0, 0, 1, 16'h0000, 1, "cc_zero");
    cycle(0, 0, 0, 0, 0, 1, 16'h7FFF, 1, "cc_pos");
    cycle(0, 0, 0, 0, 0, 0, 16'h0, 1, "cc_after_pos");

    cycle(0, 1, 2, 2, 2, 0, 16'hA5A5, 1, "bypass_same");
    cycle(0, 0, 0, 2, 2, 0, 16'h0, 1, "bypass_after");

    cycle(0, 1, 7, 0, 0, 0, 16'hFFFF, 1, "wr_r7");
    cycle(1, 1, 7, 7, 7, 1, 16'h1111, 1, "reset_dominates");
    cycle(0, 0, 0, 7, 7, 0, 16'h0, 1, "after_reset");

    xdr = 3'bxxx;
    cycle(0, 1, 4, 4, 0, 0, 16'h4444, 1, "wr_r4");
    cycle(0, 0, xdr, 4, 1, 0, 16'hDEAD, 1, "x_dr_idle");
    cycle(0, 0, 0, 4, 1, 0, 16'h0, 1, "x_dr_after");

    for (int k = 0; k < 10000; k++) begin
      case ($urandom_range(0, 7))
        0: v = 16'h0000;
        1: v = 16'h8000;
        2: v = 16'h7FFF;
        3: v = 16'hFFFF;
        default: v = 16'($urandom);
      endcase
      cycle(($urandom_range(0, 127) == 0), 1'($urandom), 3'($urandom), 3'($urandom),
            3'($urandom), 1'($urandom), v, 1, "random");
    end

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
